// File: rtl/gauge_sweep_controller_if.sv
// gauge_sweep_controller_if: command/status bundle between the speed datapath, the gauge controller and the servo driver
interface gauge_sweep_controller_if;
   logic       enable;
   logic [7:0] target_speed;
   logic       selftest_start;
   logic [7:0] servo_speed;
   logic       frame_tick;
   logic       busy;
   logic       at_target;
   modport master (output enable, target_speed, selftest_start,
                   input  servo_speed, frame_tick, busy, at_target);
   modport slave  (input  enable, target_speed, selftest_start,
                   output servo_speed, frame_tick, busy, at_target);
endinterface

// File: rtl/gauge_sweep_controller.sv
// gauge_sweep_controller: needle self-test sweep plus slew-limited tracking/parking, updated once per servo frame
module gauge_sweep_controller #(
   parameter int FRAME_CYCLES = 1_000_000,
   parameter int STEP         = 4,
   parameter int SWEEP_STEP   = 8,
   parameter int HOLD_FRAMES  = 25
) (
   input logic                     clk,
   input logic                     rst,
   gauge_sweep_controller_if.slave bus
);
   localparam int CW = $clog2(FRAME_CYCLES);
   localparam int HW = $clog2(HOLD_FRAMES + 1);
   typedef enum logic [2:0] {SWEEP_UP, HOLD, SWEEP_DOWN, TRACK, PARK} state_t;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;
   logic [7:0]    speed_q, speed_d;
   logic [HW-1:0] hold_q, hold_d, hold_inc;
   logic          req_q, req_d;
   logic          idle, go_up;
   logic [8:0]    up_sum;
   logic [7:0]    up_val, down_val, park_val, track_val, diff;
   assign tick_d   = cnt_q == CW'(FRAME_CYCLES - 1);
   assign cnt_d    = tick_d ? '0 : cnt_q + CW'(1);
   assign idle     = state_q == TRACK || state_q == PARK;
   assign up_sum   = {1'b0, speed_q} + 9'(SWEEP_STEP);
   assign up_val   = up_sum[8] ? 8'hFF : up_sum[7:0];
   assign down_val = speed_q <= 8'(SWEEP_STEP) ? 8'd0 : speed_q - 8'(SWEEP_STEP);
   assign park_val = speed_q <= 8'(STEP) ? 8'd0 : speed_q - 8'(STEP);
   assign go_up    = bus.target_speed > speed_q;
   assign diff     = go_up ? bus.target_speed - speed_q : speed_q - bus.target_speed;
   // a gap larger than STEP guarantees speed_q +/- STEP stays strictly between speed_q and target
   assign track_val = diff <= 8'(STEP) ? bus.target_speed :
                      go_up ? speed_q + 8'(STEP) : speed_q - 8'(STEP);
   assign hold_inc = hold_q + HW'(1);
   // a start on the tick cycle itself is consumed by that tick rather than latched
   assign req_d    = tick_q ? 1'b0 : req_q | (idle & bus.selftest_start);
   always_comb begin
      state_d = state_q;
      speed_d = speed_q;
      hold_d  = hold_q;
      case (state_q)
         SWEEP_UP: if (tick_q) begin
            speed_d = up_val;
            if (up_val == 8'hFF) begin
               state_d = HOLD;
               hold_d  = '0;
            end
         end
         HOLD: if (tick_q) begin
            hold_d = hold_inc;
            if (hold_inc == HW'(HOLD_FRAMES)) state_d = SWEEP_DOWN;
         end
         SWEEP_DOWN: if (tick_q) begin
            speed_d = down_val;
            if (down_val == 8'd0) state_d = bus.enable ? TRACK : PARK;
         end
         TRACK, PARK: if (tick_q) begin
            if (req_q | bus.selftest_start) state_d = SWEEP_UP;
            else begin
               state_d = bus.enable ? TRACK : PARK;
               speed_d = bus.enable ? track_val : park_val;
            end
         end
         default: state_d = PARK;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= SWEEP_UP;
         cnt_q   <= '0;
         tick_q  <= 1'b0;
         speed_q <= 8'd0;
         hold_q  <= '0;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tick_q  <= tick_d;
         speed_q <= speed_d;
         hold_q  <= hold_d;
         req_q   <= req_d;
      end
   end
   assign bus.servo_speed = speed_q;
   assign bus.frame_tick  = tick_q;
   assign bus.busy        = state_q == SWEEP_UP || state_q == HOLD || state_q == SWEEP_DOWN;
   assign bus.at_target   = state_q == TRACK && speed_q == bus.target_speed;
endmodule

// File: tb/tb_gauge_sweep_controller.sv
// tb_gauge_sweep_controller: scoreboard bench; a frame-level model queues expected needle state, a monitor checks it
module tb_gauge_sweep_controller;
   localparam int FC = 10, ST = 4, SS = 64, HF = 2;
   typedef struct packed {int servo; bit busy; bit track;} exp_t;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   gauge_sweep_controller_if bus ();
   gauge_sweep_controller #(.FRAME_CYCLES(FC), .STEP(ST), .SWEEP_STEP(SS), .HOLD_FRAMES(HF))
      dut (.clk(clk), .rst(rst), .bus(bus));
   exp_t sb[$];
   int   sweep[$];
   int   m_servo, cyc_cnt, reset_cnt = 0, seen = 0, checks = 0, failures = 0;
   bit   m_track, m_req, tick_now, prev_tick;
   exp_t cur;
   // the whole self-test is precomputed as the list of needle positions, one per frame
   function void build_sweep();
      int v;
      v = m_servo;
      do begin v = v + SS > 255 ? 255 : v + SS; sweep.push_back(v); end while (v != 255);
      repeat (HF) sweep.push_back(255);
      do begin v = v < SS ? 0 : v - SS; sweep.push_back(v); end while (v != 0);
   endfunction
   function int toward(int s, int t);
      return (t - s <= ST && s - t <= ST) ? t : (t > s ? s + ST : s - ST);
   endfunction
   task automatic chk(string n, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
      end
   endtask
   initial forever begin
      @(posedge clk);
      if (!rst) begin
         sb.delete(); sweep.delete();
         m_servo = 0; m_track = 0; m_req = 0; cyc_cnt = 0; tick_now = 0;
         build_sweep();
         reset_cnt++;
      end else begin
         if (tick_now) begin
            if (sweep.size() != 0) begin
               m_servo = sweep.pop_front();
               if (sweep.size() == 0) m_track = bus.enable;
            end else if (m_req || bus.selftest_start) begin
               m_req = 0;
               build_sweep();
            end else begin
               m_track = bus.enable;
               m_servo = toward(m_servo, bus.enable ? int'(bus.target_speed) : 0);
            end
            sb.push_back('{m_servo, sweep.size() != 0, m_track});
         end else if (sweep.size() == 0 && bus.selftest_start) m_req = 1;
         cyc_cnt++;
         tick_now = cyc_cnt % FC == 0;
      end
   end
   initial forever begin
      @(negedge clk);
      if (reset_cnt != seen) begin
         seen = reset_cnt;
         cur = '{0, 1'b1, 1'b0};
         prev_tick = 0;
      end else if (prev_tick) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard: got update with empty queue at %0t", $time);
         end else cur = sb.pop_front();
      end
      if (seen != 0) begin
         chk("frame_tick", int'(bus.frame_tick), int'(tick_now));
         chk("servo_speed", int'(bus.servo_speed), cur.servo);
         chk("busy", int'(bus.busy), int'(cur.busy));
         chk("at_target", int'(bus.at_target),
             int'(!cur.busy && cur.track && cur.servo == int'(bus.target_speed)));
         prev_tick = bus.frame_tick;
      end
   end
   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic pulse_start();
      while (tick_now) cyc(1);
      bus.selftest_start = 1'b1;
      cyc(1);
      bus.selftest_start = 1'b0;
   endtask
   initial begin
      rst = 1'b0; bus.enable = 1'b1; bus.target_speed = 8'd100; bus.selftest_start = 1'b0;
      cyc(3); rst = 1'b1;
      cyc(45 * FC);
      bus.target_speed = 8'd102; cyc(2 * FC);
      bus.target_speed = 8'd0; cyc(30 * FC);
      bus.target_speed = 8'd50; cyc(15 * FC);
      bus.enable = 1'b0; cyc(20 * FC);
      bus.target_speed = 8'd8; bus.enable = 1'b1; cyc(5 * FC);
      bus.target_speed = 8'd200; cyc(60 * FC);
      cyc(3); pulse_start();
      for (int i = 0; i < 9 * FC; i++) begin
         if (i % 7 == 0) bus.enable = ~bus.enable;
         if (i % 5 == 0) bus.target_speed = 8'($urandom);
         if (i % 11 == 0 && !tick_now) bus.selftest_start = 1'b1;
         cyc(1);
         bus.selftest_start = 1'b0;
      end
      bus.enable = 1'b1; cyc(10 * FC);
      rst = 1'b0; cyc(1); rst = 1'b1;
      cyc(45);
      rst = 1'b0; cyc(3); rst = 1'b1;
      cyc(15 * FC);
      bus.target_speed = 8'd180; cyc(50 * FC);
      bus.enable = 1'b0; cyc(10 * FC);
      while (tick_now) cyc(1);
      bus.selftest_start = 1'b1; bus.enable = 1'b1; cyc(1);
      bus.selftest_start = 1'b0; cyc(15 * FC);
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 19) == 0)
            bus.target_speed = $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) ? 8'd255 : 8'd0) : 8'($urandom);
         if ($urandom_range(0, 149) == 0) bus.enable = ~bus.enable;
         bus.selftest_start = $urandom_range(0, 499) == 0 && !tick_now;
         cyc(1);
      end
      bus.selftest_start = 1'b0;
      cyc(5);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
